// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_pkg
// Description : Shared types and constants for the SPI byte master.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

    localparam int SPI_BYTE_W      = 8;
    localparam int CLK_DIV_DEFAULT = 4;

    // Controller states; explicit 3-bit encoding
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        HIGH  = 3'd2,
        LOW   = 3'd3,
        GAP   = 3'd4,
        NEXT  = 3'd5,
        HOLD  = 3'd6
    } spi_state_t;

endpackage
`default_nettype wire

// File: rtl/spi_halfper_cnt.sv
`default_nettype none
// ============================================================================
// Module      : spi_halfper_cnt
// Description : Half-period down-counter. A load starts a new CLK_DIV-cycle
//               phase; tick is high on the last cycle of that phase.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_halfper_cnt #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic tick
);

    localparam int                CNT_W    = $clog2(CLK_DIV + 1);
    localparam logic [CNT_W-1:0] c_reload = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;

    // Reload at the start of each phase, otherwise count down to zero and park
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= c_reload;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign tick = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/spi_byte_master.sv
`default_nettype none
// ============================================================================
// Module      : spi_byte_master
// Description : SPI mode-0, MSB-first byte master with a valid/ready byte
//               stream, chip-select held across non-last bytes, and abort.
//               Optional macro SPI_INTERBYTE_GAP_EN inserts a CLK_DIV-cycle
//               idle gap (CS still asserted) between consecutive bytes.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_byte_master
    import spi_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    input  logic [SPI_BYTE_W-1:0] tx_data,
    input  logic                  tx_last,
    output logic                  rx_valid,
    output logic [SPI_BYTE_W-1:0] rx_data,
    input  logic                  abort,
    output logic                  busy,
    output logic                  spi_cs_n,
    output logic                  spi_sclk,
    output logic                  spi_mosi,
    input  logic                  spi_miso
);

    localparam logic [3:0] c_full = 4'(SPI_BYTE_W);

    spi_state_t            r_state;
    logic [SPI_BYTE_W-1:0] r_shift;   // tx bits leave the top, rx bits enter the bottom
    logic [3:0]            r_bits;    // rising edges seen in the current byte
    logic                  r_last;
    logic                  w_tick;
    logic                  w_accept;
    logic                  w_timed;
    logic                  w_load;

    assign w_accept = tx_valid && tx_ready;
    assign w_timed  = (r_state inside {SETUP, HIGH, LOW, GAP, HOLD});
    // Restart the half-period timer whenever a timed phase begins
    assign w_load   = !abort && (w_accept || (w_timed && w_tick));

    spi_halfper_cnt #(
        .CLK_DIV (CLK_DIV)
    ) u_halfper_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (w_load),
        .tick  (w_tick)
    );

    // Transfer sequencer; every port output is a register written here
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_shift  <= '0;
            r_bits   <= '0;
            r_last   <= 1'b0;
            tx_ready <= 1'b0;
            rx_valid <= 1'b0;
            rx_data  <= '0;
            busy     <= 1'b0;
            spi_cs_n <= 1'b1;
            spi_sclk <= 1'b0;
            spi_mosi <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (abort) begin
                // Abort beats everything, including an accept in this cycle
                r_state  <= IDLE;
                r_bits   <= '0;
                tx_ready <= 1'b1;
                busy     <= 1'b0;
                spi_cs_n <= 1'b1;
                spi_sclk <= 1'b0;
                spi_mosi <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        tx_ready <= 1'b1;
                        if (w_accept) begin
                            r_state  <= SETUP;
                            r_shift  <= tx_data;
                            r_last   <= tx_last;
                            r_bits   <= '0;
                            tx_ready <= 1'b0;
                            busy     <= 1'b1;
                            spi_cs_n <= 1'b0;
                            spi_mosi <= tx_data[SPI_BYTE_W-1];
                        end
                    end
                    SETUP: begin
                        if (w_tick) begin
                            r_state  <= HIGH;
                            spi_sclk <= 1'b1;
                            r_shift  <= {r_shift[SPI_BYTE_W-2:0], spi_miso};
                            r_bits   <= r_bits + 4'd1;
                        end
                    end
                    HIGH: begin
                        if (w_tick) begin
                            r_state  <= LOW;
                            spi_sclk <= 1'b0;
                            if (r_bits == c_full) begin
                                rx_valid <= 1'b1;
                                rx_data  <= r_shift;
                            end else begin
                                spi_mosi <= r_shift[SPI_BYTE_W-1];
                            end
                        end
                    end
                    LOW: begin
                        if (w_tick) begin
                            if (r_bits != c_full) begin
                                r_state  <= HIGH;
                                spi_sclk <= 1'b1;
                                r_shift  <= {r_shift[SPI_BYTE_W-2:0], spi_miso};
                                r_bits   <= r_bits + 4'd1;
                            end else if (r_last) begin
                                r_state <= HOLD;
                            end else begin
`ifdef SPI_INTERBYTE_GAP_EN
                                r_state  <= GAP;
`else
                                r_state  <= NEXT;
                                tx_ready <= 1'b1;
`endif
                            end
                        end
                    end
                    GAP: begin
                        if (w_tick) begin
                            r_state  <= NEXT;
                            tx_ready <= 1'b1;
                        end
                    end
                    NEXT: begin
                        // Follow-on byte starts with a low half-period, CS stays asserted
                        if (w_accept) begin
                            r_state  <= LOW;
                            r_shift  <= tx_data;
                            r_last   <= tx_last;
                            r_bits   <= '0;
                            tx_ready <= 1'b0;
                            spi_mosi <= tx_data[SPI_BYTE_W-1];
                        end
                    end
                    HOLD: begin
                        if (w_tick) begin
                            r_state  <= IDLE;
                            tx_ready <= 1'b1;
                            busy     <= 1'b0;
                            spi_cs_n <= 1'b1;
                            spi_mosi <= 1'b0;
                        end
                    end
                    default: begin
                        r_state  <= IDLE;
                        busy     <= 1'b0;
                        spi_cs_n <= 1'b1;
                        spi_sclk <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_byte_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_byte_master
// Description : Directed self-checking bench for spi_byte_master, with one
//               CLK_DIV=2 instance (behavioural slave attached) and one
//               CLK_DIV=1 instance (MISO tied high). Expected values follow
//               SPI_INTERBYTE_GAP_EN when it is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_byte_master;

`ifdef SPI_INTERBYTE_GAP_EN
    localparam int G = 2;
`else
    localparam int G = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n = 1'b0;
    logic       abort = 1'b0;
    logic       tx_valid = 1'b0;
    logic       tx_last = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_ready, rx_valid, busy, spi_cs_n, spi_sclk, spi_mosi, spi_miso;
    logic [7:0] rx_data;

    logic       d1_valid = 1'b0;
    logic       d1_last = 1'b0;
    logic [7:0] d1_data = 8'h00;
    logic       d1_ready, d1_rx_valid, d1_busy, d1_cs_n, d1_sclk, d1_mosi, d1_miso;
    logic [7:0] d1_rx_data;
    assign d1_miso = 1'b1;

    spi_byte_master #(.CLK_DIV(2)) dut (
        .clk(clk), .rst_n(rst_n), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .tx_data(tx_data), .tx_last(tx_last), .rx_valid(rx_valid), .rx_data(rx_data),
        .abort(abort), .busy(busy), .spi_cs_n(spi_cs_n), .spi_sclk(spi_sclk),
        .spi_mosi(spi_mosi), .spi_miso(spi_miso)
    );

    spi_byte_master #(.CLK_DIV(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .tx_valid(d1_valid), .tx_ready(d1_ready),
        .tx_data(d1_data), .tx_last(d1_last), .rx_valid(d1_rx_valid), .rx_data(d1_rx_data),
        .abort(1'b0), .busy(d1_busy), .spi_cs_n(d1_cs_n), .spi_sclk(d1_sclk),
        .spi_mosi(d1_mosi), .spi_miso(d1_miso)
    );

    // Mode-0 slave: presents slave_tx MSB first, captures MOSI on rising SCLK
    logic [7:0]  slave_tx = 8'h00;
    logic [2:0]  slave_bit = 3'd0;
    logic [15:0] slave_cap = 16'h0000;
    always @(posedge spi_sclk or posedge spi_cs_n) begin
        if (spi_cs_n) begin
            slave_bit <= 3'd0;
        end else begin
            slave_bit <= slave_bit + 3'd1;
            slave_cap <= {slave_cap[14:0], spi_mosi};
        end
    end
    assign spi_miso = slave_tx[3'd7 - slave_bit];

    int nvec = 0;
    int nfail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor record for the CLK_DIV=2 instance
    int         cyc;
    int         nrise;
    int         rise_cyc [32];
    logic       rise_mosi [32];
    int         nrx;
    int         rx_cyc [4];
    logic [7:0] rx_dat [4];
    int         nrdy;
    int         rdy_cyc;
    int         nacc;
    int         cs_hi_cyc;
    logic       prev_sclk;

    task automatic start(input logic [7:0] b, input logic last);
        @(negedge clk);
        chk("ready_before_start", 32'(tx_ready), 32'd1);
        tx_data = b; tx_last = last; tx_valid = 1'b1;
        cyc = 0; nrise = 0; nrx = 0; nrdy = 0; rdy_cyc = -1; nacc = 1; cs_hi_cyc = -1;
        prev_sclk = spi_sclk;
    endtask

    task automatic mon(input int ncyc, input logic two, input logic [7:0] b1);
        logic drop;
        drop = 1'b0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                if (two) begin tx_data = b1; tx_last = 1'b1; end
                else tx_valid = 1'b0;
            end
            if (drop) begin tx_valid = 1'b0; drop = 1'b0; end
            if (spi_sclk && !prev_sclk && nrise < 32) begin
                rise_cyc[nrise] = cyc; rise_mosi[nrise] = spi_mosi; nrise++;
            end
            prev_sclk = spi_sclk;
            if (rx_valid && nrx < 4) begin rx_cyc[nrx] = cyc; rx_dat[nrx] = rx_data; nrx++; end
            if (tx_ready && !spi_cs_n) begin nrdy++; if (rdy_cyc < 0) rdy_cyc = cyc; end
            if (tx_valid && tx_ready) begin nacc++; drop = 1'b1; end
            if (spi_cs_n && cs_hi_cyc < 0) cs_hi_cyc = cyc;
        end
    endtask

    task automatic run_two(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] sl);
        slave_tx = sl;
        start(b0, 1'b0);
        mon(80, 1'b1, b1);
        chk("two_rise_count", nrise, 16);
        chk("two_rise9_cycle", rise_cyc[8], 38 + G);
        chk("two_rx_count", nrx, 2);
        chk("two_rx0_cycle", rx_cyc[0], 33);
        chk("two_rx0_data", 32'(rx_dat[0]), 32'(sl));
        chk("two_rx1_cycle", rx_cyc[1], 68 + G);
        chk("two_rx1_data", 32'(rx_dat[1]), 32'(sl));
        chk("two_ready_cycles_cs_low", nrdy, 1);
        chk("two_ready_cycle", rdy_cyc, 35 + G);
        chk("two_accepts", nacc, 2);
        chk("two_cs_high_cycle", cs_hi_cyc, 72 + G);
        chk("two_mosi_bytes", 32'(slave_cap), 32'({b0, b1}));
    endtask

    logic [7:0] e;
    logic       found;
    int         cnt;
    logic       sclk1 [32];

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_cs_n", 32'(spi_cs_n), 32'd1);
        chk("rst_sclk", 32'(spi_sclk), 32'd0);
        chk("rst_mosi", 32'(spi_mosi), 32'd0);
        chk("rst_tx_ready", 32'(tx_ready), 32'd0);
        chk("rst_rx_valid", 32'(rx_valid), 32'd0);
        chk("rst_rx_data", 32'(rx_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_d1_cs_n", 32'(d1_cs_n), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_tx_ready", 32'(tx_ready), 32'd1);
        chk("post_rst_d1_tx_ready", 32'(d1_ready), 32'd1);

        // Single last byte 0xA5, slave answers 0x3C
        slave_tx = 8'h3C;
        start(8'hA5, 1'b1);
        mon(40, 1'b0, 8'h00);
        e = 8'hA5;
        chk("one_rise_count", nrise, 8);
        for (int k = 1; k <= 8; k++) begin
            chk($sformatf("one_rise%0d_cycle", k), rise_cyc[k-1], 4 * k - 1);
            chk($sformatf("one_rise%0d_mosi", k), 32'(rise_mosi[k-1]), 32'(e[8-k]));
        end
        chk("one_rx_count", nrx, 1);
        chk("one_rx_cycle", rx_cyc[0], 33);
        chk("one_rx_data", 32'(rx_dat[0]), 32'h3C);
        chk("one_cs_high_cycle", cs_hi_cyc, 37);
        chk("one_ready_cs_low", nrdy, 0);
        chk("one_mosi_byte", 32'(slave_cap[7:0]), 32'hA5);

        // Back-to-back bytes; second one held on tx_valid during the first
        run_two(8'h01, 8'hFF, 8'hC3);
        run_two(8'h3C, 8'h99, 8'h81);

        // Abort on the 4th rising edge of 0x55
        start(8'h55, 1'b1);
        found = 1'b0;
        cnt = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) tx_valid = 1'b0;
            if (spi_sclk && !prev_sclk) begin nrise++; if (nrise == 4) found = 1'b1; end
            prev_sclk = spi_sclk;
            if (rx_valid) cnt++;
        end
        chk("abort_rise4_found", 32'(found), 32'd1);
        chk("abort_rise4_cycle", cyc, 15);
        chk("abort_busy_before", 32'(busy), 32'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_cs_n", 32'(spi_cs_n), 32'd1);
        chk("abort_sclk", 32'(spi_sclk), 32'd0);
        chk("abort_mosi", 32'(spi_mosi), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rx_valid || !spi_cs_n) cnt++;
        end
        chk("abort_no_rx_no_cs", cnt, 0);
        chk("abort_rx_data_held", 32'(rx_data), 32'h81);

        // Abort together with an accept in IDLE
        @(negedge clk);
        tx_data = 8'hAA; tx_last = 1'b1; tx_valid = 1'b1; abort = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0; abort = 1'b0;
        chk("abort_accept_busy", 32'(busy), 32'd0);
        chk("abort_accept_cs_n", 32'(spi_cs_n), 32'd1);
        repeat (3) @(negedge clk);
        chk("abort_accept_cs_n_later", 32'(spi_cs_n), 32'd1);

        // Reset at bit 5, then a clean byte
        slave_tx = 8'h55;
        start(8'hE7, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) tx_valid = 1'b0;
            if (spi_sclk && !prev_sclk) begin nrise++; if (nrise == 5) found = 1'b1; end
            prev_sclk = spi_sclk;
        end
        chk("midrst_rise5_found", 32'(found), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_cs_n", 32'(spi_cs_n), 32'd1);
        chk("midrst_sclk", 32'(spi_sclk), 32'd0);
        chk("midrst_mosi", 32'(spi_mosi), 32'd0);
        chk("midrst_tx_ready", 32'(tx_ready), 32'd0);
        chk("midrst_rx_valid", 32'(rx_valid), 32'd0);
        chk("midrst_rx_data", 32'(rx_data), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        slave_tx = 8'h96;
        start(8'h5A, 1'b1);
        mon(40, 1'b0, 8'h00);
        chk("midrst_after_rx_count", nrx, 1);
        chk("midrst_after_rx_cycle", rx_cyc[0], 33);
        chk("midrst_after_rx_data", 32'(rx_dat[0]), 32'h96);
        chk("midrst_after_mosi", 32'(slave_cap[7:0]), 32'h5A);
        chk("midrst_after_cs_high", cs_hi_cyc, 37);

        // CLK_DIV=1, 0x80 last, MISO tied high
        @(negedge clk);
        chk("d1_ready_before", 32'(d1_ready), 32'd1);
        d1_data = 8'h80; d1_last = 1'b1; d1_valid = 1'b1;
        cnt = 0;
        for (int c = 1; c <= 22; c++) begin
            @(negedge clk);
            if (c == 1) d1_valid = 1'b0;
            sclk1[c] = d1_sclk;
            if (d1_rx_valid) begin
                cnt++;
                chk("d1_rx_cycle", c, 17);
                chk("d1_rx_data", 32'(d1_rx_data), 32'hFF);
            end
            if (c == 18) chk("d1_cs_low_c18", 32'(d1_cs_n), 32'd0);
            if (c == 19) chk("d1_cs_high_c19", 32'(d1_cs_n), 32'd1);
        end
        chk("d1_rx_count", cnt, 1);
        for (int c = 1; c <= 17; c++) begin
            chk($sformatf("d1_sclk_c%0d", c), 32'(sclk1[c]), 32'((c % 2) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spi_byte_master.md
SPI_BYTE_MASTER -- requirements
Module: spi_byte_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, SPI half-period in clk cycles; legal range 1..255.
REQ-002 SHALL have port clk  input  1  sole clock; all logic is rising-edge.
REQ-003 SHALL have port rst_n  input  1  synchronous active-low reset.
REQ-004 SHALL have ports tx_valid input 1, tx_ready output 1, tx_data input 8, tx_last input 1 (deassert CS after this byte); transfer on tx_valid&&tx_ready.
REQ-005 SHALL have ports rx_valid output 1 (one-cycle strobe) and rx_data output 8 (received byte).
REQ-006 SHALL have ports abort input 1 (terminate now) and busy output 1 (state!=IDLE).
REQ-007 SHALL have ports spi_cs_n output 1, spi_sclk output 1, spi_mosi output 1, spi_miso input 1; SPI mode 0, MSB first, drives one CS line of the shared bus.

Function
REQ-008 SHALL implement states IDLE, SETUP, HIGH, LOW, GAP, NEXT, HOLD; every output registered.
REQ-009 IDLE: cs_n=1, sclk=0, tx_ready=1; on accept load shift register, cs_n=0, mosi=tx_data[7], latch tx_last, enter SETUP.
REQ-010 SETUP, HIGH, LOW, GAP, HOLD each last exactly CLK_DIV cycles, timed by one down-counter.
REQ-011 SETUP->HIGH: sclk=1; miso sampled into shift register LSB on the cycle sclk rises.
REQ-012 HIGH->LOW: sclk=0; mosi advances to next bit on the same cycle, except after bit 0.
REQ-013 On the cycle sclk falls after the 8th rising edge, rx_valid=1 for exactly one cycle; rx_data updated in that cycle, held until next rx_valid.
REQ-014 End of 8th LOW: latched tx_last=1 -> HOLD then IDLE (cs_n=1 on IDLE entry); tx_last=0 -> NEXT (via GAP when configured).
REQ-015 NEXT: cs_n=0, sclk=0, tx_ready=1, waits indefinitely; on accept load byte, mosi=tx_data[7], enter LOW (one half-period), then HIGH.
REQ-016 tx_ready SHALL be 0 in SETUP, HIGH, LOW, GAP, HOLD; tx_valid there ignored, no data lost or captured.
REQ-017 abort=1 in any state SHALL, next cycle, force IDLE, cs_n=1, sclk=0, mosi=0, no rx_valid; abort wins over simultaneous accept.
REQ-018 CLK_DIV=1 SHALL yield sclk = clk/2 with identical state sequence.
REQ-019 Byte timing from IDLE accept at cycle 0: rising edges at k*2*CLK_DIV-CLK_DIV+1 (k=1..8), rx_valid at 16*CLK_DIV+1.

Reset
REQ-020 rst_n=0 sampled on clk edge SHALL give: state IDLE, cs_n=1, sclk=0, mosi=0, tx_ready=0 during reset and 1 the first cycle after, rx_valid=0, rx_data=0, busy=0, counters 0.
REQ-021 Reset mid-transfer SHALL behave as abort, with no partial byte reported.

Configuration
REQ-022 Macro SPI_INTERBYTE_GAP_EN defined: non-last byte SHALL pass through GAP (CLK_DIV cycles, cs_n=0, sclk=0, tx_ready=0) before NEXT.
REQ-023 Macro undefined: GAP state SHALL be unreachable; 8th LOW goes directly to NEXT.

Structure
REQ-024 Package spi_pkg SHALL hold the state enum typedef, SPI_BYTE_W=8, and CLK_DIV_DEFAULT=4.
REQ-025 Half-period down-counter SHALL be sub-module spi_halfper_cnt (load, tick-out), width $clog2(CLK_DIV+1).

Verification
REQ-026 CLK_DIV=2, send 0xA5 last, slave returns 0x3C -> mosi bits 1,0,1,0,0,1,0,1 at rising edges 3,7..31; rx_valid at cycle 33 with rx_data=0x3C; cs_n=1 at cycle 37.
REQ-027 CLK_DIV=2, send 0x01 (tx_last=0), then 0xFF last offered immediately -> cs_n stays 0 between bytes, tx_ready=1 only in NEXT, two rx_valid strobes, gap per SPI_INTERBYTE_GAP_EN.
REQ-028 Abort asserted at 4th rising edge of 0x55 -> next cycle cs_n=1, sclk=0, busy=0, no rx_valid.
REQ-029 tx_valid held high with 0x99 throughout HIGH/LOW -> only first byte transferred; held byte accepted in NEXT only.
REQ-030 CLK_DIV=1, send 0x80 last with miso tied 1 -> sclk toggles every cycle, rx_data=0xFF at cycle 17.
REQ-031 rst_n low at bit 5 of a transfer -> following cycle all outputs at REQ-020 values; subsequent byte completes normally.
